// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style ultrasonic sensor emulator: answers a trig pulse with an echo pulse
// whose width encodes distance_cm. Define ECHO_SYNC_EN for a two-flop trig synchronizer.
module ultrasonic_echo_responder #(
  parameter int unsigned CLKS_PER_US    = 50,
  parameter int unsigned MIN_TRIG_US    = 10,
  parameter int unsigned BURST_DELAY_US = 200,
  parameter int unsigned US_PER_CM      = 58,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned TIMEOUT_US     = 38000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int unsigned CNT_W        = 21;
  localparam int unsigned MIN_TRIG_CYC = MIN_TRIG_US * CLKS_PER_US;
  localparam int unsigned BURST_CYC    = BURST_DELAY_US * CLKS_PER_US;
  localparam int unsigned CYC_PER_CM   = US_PER_CM * CLKS_PER_US;
  localparam int unsigned TIMEOUT_CYC  = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned TW           = $clog2(MIN_TRIG_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    wcnt, wcnt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [CNT_W-1:0] echo_width_c;
  logic             trig_err_nxt;
  logic             trig_s, trig_s_d;
  logic             trig_rise_c;

  // Trigger front end: produces trig_s for edge detection
`ifdef ECHO_SYNC_EN
  logic trig_meta;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
    end
  end
`else
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      trig_s <= 1'b0;
    end else begin
      trig_s <= trig;
    end
  end
`endif

  // trig_s_d tracks trig_s in every state, so a trig held high across a
  // measurement never looks like a fresh edge when IDLE is re-entered
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      trig_s_d <= 1'b0;
    end else begin
      trig_s_d <= trig_s;
    end
  end

  assign trig_rise_c = trig_s & ~trig_s_d;

  // Echo width for the currently presented distance; out-of-range means "no object"
  always_comb begin
    echo_width_c = CNT_W'(TIMEOUT_CYC);
    if ((distance_cm != 9'd0) && (32'(distance_cm) <= MAX_CM)) begin
      echo_width_c = CNT_W'(32'(distance_cm) * CYC_PER_CM);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      cnt      <= '0;
      width    <= '0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      cnt      <= cnt_nxt;
      width    <= width_nxt;
      echo     <= (state_nxt == ECHO);
      busy     <= (state_nxt == BURST) || (state_nxt == ECHO);
      trig_err <= trig_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    cnt_nxt      = cnt;
    width_nxt    = width;
    trig_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        // The edge cycle is itself a high cycle, so the count starts at one
        if (trig_rise_c) begin
          state_nxt = TRIG_HI;
          wcnt_nxt  = TW'(1);
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (wcnt != TW'(MIN_TRIG_CYC)) begin
            wcnt_nxt = wcnt + TW'(1);
          end
        end else if (wcnt >= TW'(MIN_TRIG_CYC)) begin
          state_nxt = BURST;
          cnt_nxt   = '0;
          width_nxt = echo_width_c;
        end else begin
          state_nxt    = IDLE;
          trig_err_nxt = 1'b1;
        end
      end
      BURST: begin
        if (cnt == CNT_W'(BURST_CYC - 1)) begin
          state_nxt = ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt == width - CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder, run with scaled-down timing parameters.
module tb_ultrasonic_echo_responder;

  localparam int unsigned CLKS_PER_US    = 2;
  localparam int unsigned MIN_TRIG_US    = 5;
  localparam int unsigned BURST_DELAY_US = 10;
  localparam int unsigned US_PER_CM      = 3;
  localparam int unsigned MAX_CM         = 400;
  localparam int unsigned TIMEOUT_US     = 1300;

  localparam int unsigned MIN_TRIG_CYC = MIN_TRIG_US * CLKS_PER_US;   // 10
  localparam int unsigned BURST_CYC    = BURST_DELAY_US * CLKS_PER_US; // 20
  localparam int unsigned CYC_PER_CM   = US_PER_CM * CLKS_PER_US;     // 6
  localparam int unsigned TIMEOUT_CYC  = TIMEOUT_US * CLKS_PER_US;    // 2600
`ifdef ECHO_SYNC_EN
  localparam int unsigned LAG = 2;
`else
  localparam int unsigned LAG = 1;
`endif

  typedef struct {
    int unsigned rise;
    int unsigned width;
  } exp_t;

  logic       clk_50M = 1'b0;
  logic       reset = 1'b1;
  logic       trig = 1'b0;
  logic [8:0] distance_cm = 9'd0;
  logic       echo, busy, trig_err;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  int unsigned err_q[$];
  logic        echo_p = 1'b0, busy_p = 1'b0, err_p = 1'b0;
  int unsigned echo_rise = 0;

  ultrasonic_echo_responder #(
    .CLKS_PER_US   (CLKS_PER_US),
    .MIN_TRIG_US   (MIN_TRIG_US),
    .BURST_DELAY_US(BURST_DELAY_US),
    .US_PER_CM     (US_PER_CM),
    .MAX_CM        (MAX_CM),
    .TIMEOUT_US    (TIMEOUT_US)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned model_width(input int unsigned d);
    if (d == 0 || d > MAX_CM) return TIMEOUT_CYC;
    return d * CYC_PER_CM;
  endfunction

  // k: cycle index at which trig was driven low
  task automatic push_accept(input int unsigned k, input int unsigned d);
    exp_t e;
    e.rise  = k + 1 + LAG + BURST_CYC;
    e.width = model_width(d);
    exp_q.push_back(e);
  endtask

  // kind: 0 = expected ignored, 1 = accepted, 2 = rejected
  task automatic pulse(input int unsigned n, input int unsigned d, input int kind);
    int unsigned k;
    distance_cm = 9'(d);
    @(posedge clk_50M); #1 trig = 1'b1;
    repeat (n) @(posedge clk_50M);
    #1 trig = 1'b0;
    k = cyc;
    if (kind == 1) push_accept(k, d);
    else if (kind == 2) err_q.push_back(k + 1 + LAG);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk_50M);
      n++;
    end
    if (n >= budget) check_eq("idle_timeout", n, 0);
    repeat (3) @(posedge clk_50M);
    #1;
  endtask

  task automatic wait_echo(input int unsigned budget);
    int unsigned n = 0;
    while (!echo && n < budget) begin
      @(posedge clk_50M);
      n++;
    end
    if (n >= budget) check_eq("echo_timeout", n, 0);
    #1;
  endtask

  // Output monitor: compares echo/busy/trig_err activity against the scoreboard
  always @(negedge clk_50M) begin
    exp_t e;
    if (!reset || echo_p || busy_p) begin
      if (echo && !echo_p) begin
        echo_rise = cyc;
        if (exp_q.size() == 0) check_eq("echo_unexpected", 1, 0);
        else check_eq("echo_rise", cyc, exp_q[0].rise);
      end
      if (!echo && echo_p && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("echo_width", cyc - echo_rise, e.width);
        check_eq("busy_at_fall", 32'(busy), 0);
      end
      if (busy && !busy_p) begin
        if (exp_q.size() == 0) check_eq("busy_unexpected", 1, 0);
        else check_eq("busy_rise", cyc, exp_q[0].rise - BURST_CYC);
      end
      if (!busy && busy_p && !echo_p) check_eq("busy_fall_early", 1, 0);
      if (trig_err) begin
        if (err_p) check_eq("trig_err_len", 2, 1);
        else if (err_q.size() == 0) check_eq("trig_err_unexpected", 1, 0);
        else check_eq("trig_err_cyc", cyc, err_q.pop_front());
      end
    end
    echo_p = echo;
    busy_p = busy;
    err_p  = trig_err;
  end

  initial begin
    int unsigned r;
    repeat (3) @(posedge clk_50M);
    #1;
    check_eq("rst_echo", 32'(echo), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_trig_err", 32'(trig_err), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk_50M);

    // Exactly-minimum trigger accepted, one short rejected, then normal again
    pulse(MIN_TRIG_CYC, 7, 1);
    wait_idle(6000);
    pulse(MIN_TRIG_CYC - 1, 7, 2);
    wait_idle(200);
    check_eq("reject_busy", 32'(busy), 0);
    pulse(50, 7, 1);
    wait_idle(6000);

    // Distance boundaries
    pulse(MIN_TRIG_CYC, 0, 1);   wait_idle(6000);
    pulse(MIN_TRIG_CYC, 401, 1); wait_idle(6000);
    pulse(MIN_TRIG_CYC, 400, 1); wait_idle(6000);
    pulse(MIN_TRIG_CYC, 1, 1);   wait_idle(6000);
    pulse(MIN_TRIG_CYC, 511, 1); wait_idle(6000);

    // Distance change and extra trigger during ECHO are ignored
    pulse(MIN_TRIG_CYC, 5, 1);
    wait_echo(500);
    pulse(12, 9, 0);
    wait_idle(6000);

    // Trig held high across ECHO end needs a fresh edge
    pulse(MIN_TRIG_CYC, 2, 1);
    wait_echo(500);
    trig = 1'b1;
    wait_idle(6000);
    repeat (20) @(posedge clk_50M);
    #1 check_eq("held_no_start", 32'(busy), 0);
    trig = 1'b0;
    repeat (5) @(posedge clk_50M);
    pulse(MIN_TRIG_CYC, 3, 1);
    wait_idle(6000);

    // Trigger held very long: no echo until it falls, then accepted
    distance_cm = 9'd6;
    @(posedge clk_50M); #1 trig = 1'b1;
    repeat (300) @(posedge clk_50M);
    #1;
    check_eq("long_trig_busy", 32'(busy), 0);
    check_eq("long_trig_echo", 32'(echo), 0);
    trig = 1'b0;
    push_accept(cyc, 6);
    wait_idle(6000);

    // Reset mid-ECHO truncates the pulse; next measurement is clean
    pulse(MIN_TRIG_CYC, 400, 1);
    wait_echo(500);
    repeat (50) @(posedge clk_50M);
    #1 reset = 1'b1;
    r = cyc;
    exp_q[0].width = r + 1 - exp_q[0].rise;
    @(posedge clk_50M);
    #1 reset = 1'b0;
    check_eq("midrst_echo", 32'(echo), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_trig_err", 32'(trig_err), 0);
    wait_idle(200);
    pulse(MIN_TRIG_CYC, 7, 1);
    wait_idle(6000);

    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("err_q_empty", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
